blake2s_block_sched: RTL and testbench
======================================

# blake2s_block_sched

Input-side controller for the BLAKE2s hash core. Accepts an arbitrary-length message as a byte stream with valid/ready handshake and packs it into 64-byte blocks in an internal buffer. Each block is then replayed into the core's byte-serial load port with first/last flags, zero padding and the running byte count. After the final block it waits for the core's completion and reports done. It sits between the message source (DMA/CPU shim) and `blake2s_hash256`. Secret keys are not supported.

## Interface
- `BB`, 64: block size in bytes; the index width is log2(BB) = 6.
- `LLW`, 64: width of the message byte counter.
- `clk` in 1: clock; all logic is on the rising edge.
- `nreset` in 1: synchronous, active-high reset (1 = reset). One clock, synchronous reset, active-high.
- `start_i` in 1: starts a hash. Sampled only in IDLE.
- `nn_i` in 8: digest length in bytes, 1..32. Latched on `start_i`.
- `empty_i` in 1: with `start_i`, the message is zero length and no stream bytes follow.
- `busy_o` out 1: high whenever the state is not IDLE.
- `s_valid_i` in 1: the upstream byte is valid.
- `s_ready_o` out 1: the block can take a byte.
- `s_data_i` in 8: message byte.
- `s_last_i` in 1: this byte is the final message byte.
- `core_ready_i` in 1: the core is idle and can take a block.
- `finished_i` in 1: one-cycle pulse from the core when the digest is ready.
- `kk_o` out 8: key length. Constant 0.
- `nn_o` out 8: latched `nn_i`.
- `ll_o` out LLW: cumulative message bytes up to and including the current block.
- `block_first_o` out 1: the current block is the first block of the message.
- `block_last_o` out 1: the current block is the final block of the message.
- `data_v_o` out 1: byte strobe to the core.
- `data_idx_o` out 6: byte index within the block.
- `data_o` out 8: byte to the core.
- `done_o` out 1: one-cycle pulse when the hash is complete.

## Operation
- States: IDLE, FILL, ARB, STREAM, WAIT_DONE.
- IDLE, on `start_i`:
  - Latch `nn_i`. Clear `ll`, `cnt` and the last flag. Set the first flag.
  - If `empty_i` = 1: set the last flag and go to ARB with `cnt` = 0.
  - Otherwise go to FILL.
  - `start_i` in any other state is ignored.
- FILL:
  - `s_ready_o` = 1 here and only here.
  - On a handshake (`s_valid_i` & `s_ready_o`): `buf[cnt]` <= `s_data_i`, then `cnt++` and `ll++`.
  - If `s_last_i` is high on the handshake, or `cnt` was 63: set the last flag from `s_last_i` and go to ARB.
  - Bytes arriving while not in FILL are not consumed.
- ARB: wait for `core_ready_i` = 1, then go to STREAM with `idx` = 0.
- STREAM: for 64 consecutive cycles, with `idx` = 0..63:
  - `data_v_o` = 1 and `data_idx_o` = `idx`.
  - `data_o` = `buf[idx]` if `idx` < `cnt`, else 0x00 (zero padding).
  - `block_first_o` = first flag, `block_last_o` = last flag. `ll_o` is held stable.
  - After `idx` = 63: clear the first flag and `cnt`. If the last flag is set, go to WAIT_DONE; otherwise go to FILL.
- WAIT_DONE: on `finished_i`, pulse `done_o` for one cycle and go to IDLE. A `finished_i` in any other state is ignored.
- A message whose final byte is byte 64 of a block produces no extra padding block. That full block carries `block_last_o` = 1.
- `ll` wraps modulo 2^LLW. BLAKE2s limits messages to below 2^64 bytes, so this is outside the supported range.

## Timing
- All outputs are registered except `s_ready_o`, which is decoded from the state.
- `busy_o` is also decoded from the state.
- Reset values:
  - state IDLE.
  - `busy_o`, `s_ready_o`, `data_v_o`, `block_first_o`, `block_last_o`, `done_o` = 0.
  - `data_idx_o`, `data_o`, `nn_o`, `kk_o`, `ll_o` = 0.
  - `cnt`, `idx`, `ll` = 0.
- `start_i` high at cycle t gives `busy_o` = 1 at t+1.
- The last FILL handshake at t puts the block in ARB at t+1.
- `core_ready_i` high in ARB at t gives the first `data_v_o` at t+1.
- Streaming takes 64 cycles with no bubbles.
- Block stream to block stream: at least 64 cycles plus the fill time.
- `done_o` asserts the cycle after `finished_i`.
- Reset at any point, mid-fill or mid-stream, returns the block to reset values on the next edge. The partially issued block is abandoned.

## Test plan
- "abc" (0x61 0x62 0x63, `s_last_i` on 0x63), `nn_i` = 32 -> one stream with idx 0..2 = 61/62/63 and idx 3..63 = 00; first = last = 1; `ll_o` = 3; `finished_i` -> `done_o` pulse and `busy_o` low.
- `start_i` with `empty_i` = 1 -> one stream of 64 × 0x00; first = last = 1; `ll_o` = 0; no `s_ready_o` cycle.
- 64-byte message 0x00..0x3F, last on byte 63 -> exactly one block with data = idx; first = last = 1; `ll_o` = 64.
- 65-byte message -> block 0: first = 1, last = 0, `ll_o` = 64. Block 1: first = 0, last = 1, `ll_o` = 65, idx 0 = byte 64, rest 0x00.
- `core_ready_i` held low 10 cycles in ARB, with random `s_valid_i` gaps in FILL -> no `data_v_o` while waiting, `s_ready_o` = 0 outside FILL, no byte lost or duplicated.
- `nreset` asserted at STREAM idx 20 -> next cycle all outputs at reset values and state IDLE. Also: `start_i` pulsed while busy -> ignored, the current hash completes unchanged.

Source files
------------

// File: rtl/blake2s_block_sched.sv
`default_nettype none
// ============================================================================
// Module   : blake2s_block_sched
// Brief    : Packs a byte stream into 64-byte blocks and replays each block
//            into the BLAKE2s core load port with flags, padding and count.
// Revision : 1.0 - initial release
// ============================================================================
module blake2s_block_sched #(
    parameter int BB  = 64,
    parameter int LLW = 64
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  start_i,
    input  logic [7:0]            nn_i,
    input  logic                  empty_i,
    output logic                  busy_o,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [7:0]            s_data_i,
    input  logic                  s_last_i,
    input  logic                  core_ready_i,
    input  logic                  finished_i,
    output logic [7:0]            kk_o,
    output logic [7:0]            nn_o,
    output logic [LLW-1:0]        ll_o,
    output logic                  block_first_o,
    output logic                  block_last_o,
    output logic                  data_v_o,
    output logic [$clog2(BB)-1:0] data_idx_o,
    output logic [7:0]            data_o,
    output logic                  done_o
);

    localparam int            IW         = $clog2(BB);
    localparam logic [IW-1:0] c_IDX_LAST = IW'(BB - 1);
    localparam logic [IW:0]   c_CNT_LAST = (IW + 1)'(BB - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_ARB       = 3'd2,
        S_STREAM    = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_buf [BB];
    logic [IW:0]    r_cnt;
    logic [IW-1:0]  r_idx;
    logic [LLW-1:0] r_ll;
    logic           r_first;
    logic           r_last;
    logic [7:0]     r_nn;
    logic [LLW-1:0] r_ll_o;
    logic           r_blk_first;
    logic           r_blk_last;
    logic           r_data_v;
    logic [7:0]     r_data;
    logic           r_done;

    logic           w_hs;
    logic           w_fill_end;
    logic [IW-1:0]  w_idx_nxt;
    logic [IW-1:0]  w_rd_idx;
    logic [7:0]     w_rd_data;

    assign w_hs       = (r_state == S_FILL) & s_valid_i;
    assign w_fill_end = w_hs & (s_last_i | (r_cnt == c_CNT_LAST));
    assign w_idx_nxt  = r_idx + 1'b1;
    // The byte presented on the next cycle: index 0 when leaving ARB, else idx+1
    assign w_rd_idx   = (r_state == S_ARB) ? '0 : w_idx_nxt;
    assign w_rd_data  = ({1'b0, w_rd_idx} < r_cnt) ? r_buf[w_rd_idx] : 8'h00;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (start_i) w_state_nxt = empty_i ? S_ARB : S_FILL;
            S_FILL:      if (w_fill_end) w_state_nxt = S_ARB;
            S_ARB:       if (core_ready_i) w_state_nxt = S_STREAM;
            S_STREAM:    if (r_idx == c_IDX_LAST) w_state_nxt = r_last ? S_WAIT_DONE : S_FILL;
            S_WAIT_DONE: if (finished_i) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nreset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!nreset && w_hs) r_buf[r_cnt[IW-1:0]] <= s_data_i;
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_ll        <= '0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_nn        <= 8'h00;
            r_ll_o      <= '0;
            r_blk_first <= 1'b0;
            r_blk_last  <= 1'b0;
            r_data_v    <= 1'b0;
            r_data      <= 8'h00;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == S_WAIT_DONE) & finished_i;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_nn    <= nn_i;
                        r_ll    <= '0;
                        r_cnt   <= '0;
                        r_first <= 1'b1;
                        r_last  <= empty_i;
                    end
                end
                S_FILL: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt + 1'b1;
                        r_ll  <= r_ll + LLW'(1);
                    end
                    if (w_fill_end) r_last <= s_last_i;
                end
                S_ARB: begin
                    if (core_ready_i) begin
                        r_idx       <= '0;
                        r_data_v    <= 1'b1;
                        r_data      <= w_rd_data;
                        r_blk_first <= r_first;
                        r_blk_last  <= r_last;
                        r_ll_o      <= r_ll;
                    end
                end
                S_STREAM: begin
                    if (r_idx == c_IDX_LAST) begin
                        r_idx       <= '0;
                        r_cnt       <= '0;
                        r_first     <= 1'b0;
                        r_data_v    <= 1'b0;
                        r_data      <= 8'h00;
                        r_blk_first <= 1'b0;
                        r_blk_last  <= 1'b0;
                    end else begin
                        r_idx  <= w_idx_nxt;
                        r_data <= w_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o        = (r_state != S_IDLE);
    assign s_ready_o     = (r_state == S_FILL);
    assign kk_o          = 8'h00;
    assign nn_o          = r_nn;
    assign ll_o          = r_ll_o;
    assign block_first_o = r_blk_first;
    assign block_last_o  = r_blk_last;
    assign data_v_o      = r_data_v;
    assign data_idx_o    = r_idx;
    assign data_o        = r_data;
    assign done_o        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_blake2s_block_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_blake2s_block_sched
// Brief    : Randomized bench for blake2s_block_sched against a block model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blake2s_block_sched;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start_i;
    logic [7:0]  nn_i;
    logic        empty_i;
    logic        busy_o;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [7:0]  s_data_i;
    logic        s_last_i;
    logic        core_ready_i;
    logic        finished_i;
    logic [7:0]  kk_o;
    logic [7:0]  nn_o;
    logic [63:0] ll_o;
    logic        block_first_o;
    logic        block_last_o;
    logic        data_v_o;
    logic [5:0]  data_idx_o;
    logic [7:0]  data_o;
    logic        done_o;

    blake2s_block_sched #(.BB(64), .LLW(64)) dut (
        .clk(clk), .nreset(nreset), .start_i(start_i), .nn_i(nn_i), .empty_i(empty_i),
        .busy_o(busy_o), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .s_last_i(s_last_i), .core_ready_i(core_ready_i), .finished_i(finished_i),
        .kk_o(kk_o), .nn_o(nn_o), .ll_o(ll_o), .block_first_o(block_first_o),
        .block_last_o(block_last_o), .data_v_o(data_v_o), .data_idx_o(data_idx_o),
        .data_o(data_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         filled = 0;
    logic [7:0] cur_nn = 8'h00;
    logic [7:0] msg[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: message split into 64-byte blocks, zero padded, at least one block
    function automatic int n_blocks();
        return (msg.size() == 0) ? 1 : (msg.size() + 63) / 64;
    endfunction

    function automatic logic [7:0] exp_byte(input int k, input int i);
        int p;
        p = 64 * k + i;
        return (p < msg.size()) ? msg[p] : 8'h00;
    endfunction

    function automatic longint exp_ll(input int k);
        return (64 * (k + 1) < msg.size()) ? longint'(64 * (k + 1)) : longint'(msg.size());
    endfunction

    task automatic fill_rand(input int len);
        msg.delete();
        for (int j = 0; j < len; j++) msg.push_back(8'($urandom));
    endtask

    task automatic start_msg(input logic [7:0] nn);
        @(negedge clk);
        start_i = 1'b1;
        nn_i    = nn;
        empty_i = (msg.size() == 0);
        cur_nn  = nn;
        filled  = (msg.size() == 0) ? 1 : 0;
        @(negedge clk);
        start_i = 1'b0;
        empty_i = 1'b0;
        nn_i    = 8'h00;
        chk("busy_after_start", busy_o, 1);
        chk("nn_latch", nn_o, nn);
        chk("kk_zero", kk_o, 0);
        chk("s_ready_after_start", s_ready_o, msg.size() != 0);
    endtask

    task automatic drive_bytes();
        for (int j = 0; j < msg.size(); j++) begin
            int w;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            s_valid_i = 1'b1;
            s_data_i  = msg[j];
            s_last_i  = (j == msg.size() - 1);
            w = 0;
            while (!s_ready_o && w < 400) begin
                @(negedge clk);
                w++;
            end
            chk("hs_wait_ok", w < 400, 1);
            @(negedge clk);
            s_valid_i = 1'b0;
            s_last_i  = 1'b0;
            if (j % 64 == 63 || j == msg.size() - 1) filled++;
        end
    endtask

    task automatic watch_blocks(input int hold, input bit poke);
        for (int k = 0; k < n_blocks(); k++) begin
            int w;
            w = 0;
            while (filled <= k && w < 2000) begin
                @(negedge clk);
                w++;
            end
            chk("fill_wait_ok", w < 2000, 1);
            repeat (hold) begin
                chk("no_v_in_arb", data_v_o, 0);
                chk("no_rdy_in_arb", s_ready_o, 0);
                @(negedge clk);
            end
            core_ready_i = 1'b1;
            @(negedge clk);
            core_ready_i = 1'b0;
            for (int i = 0; i < 64; i++) begin
                chk("data_v", data_v_o, 1);
                chk("idx", data_idx_o, 64'(i));
                chk("data", data_o, exp_byte(k, i));
                chk("first", block_first_o, k == 0);
                chk("last", block_last_o, k == n_blocks() - 1);
                chk("ll", ll_o, exp_ll(k));
                chk("rdy_in_stream", s_ready_o, 0);
                if (poke) begin
                    start_i = (k == 0 && i == 10);
                    empty_i = start_i;
                    nn_i    = 8'hEE;
                end
                @(negedge clk);
            end
            start_i = 1'b0;
            empty_i = 1'b0;
            chk("v_after_stream", data_v_o, 0);
        end
        repeat ($urandom_range(0, 3)) begin
            chk("no_early_done", done_o, 0);
            chk("busy_wait", busy_o, 1);
            @(negedge clk);
        end
        finished_i = 1'b1;
        @(negedge clk);
        finished_i = 1'b0;
        chk("done_pulse", done_o, 1);
        chk("busy_cleared", busy_o, 0);
        chk("nn_hold", nn_o, cur_nn);
        @(negedge clk);
        chk("done_single", done_o, 0);
    endtask

    task automatic run_msg(input logic [7:0] nn, input int hold, input bit poke);
        start_msg(nn);
        fork
            drive_bytes();
            watch_blocks(hold, poke);
        join
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_rdy"}, s_ready_o, 0);
        chk({tag, "_v"}, data_v_o, 0);
        chk({tag, "_first"}, block_first_o, 0);
        chk({tag, "_last"}, block_last_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_idx"}, data_idx_o, 0);
        chk({tag, "_data"}, data_o, 0);
        chk({tag, "_nn"}, nn_o, 0);
        chk({tag, "_kk"}, kk_o, 0);
        chk({tag, "_ll"}, ll_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b1; start_i = 1'b0; nn_i = 8'h00; empty_i = 1'b0;
        s_valid_i = 1'b0; s_data_i = 8'h00; s_last_i = 1'b0;
        core_ready_i = 1'b0; finished_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        nreset = 1'b0;

        msg = {8'h61, 8'h62, 8'h63};
        run_msg(8'd32, 0, 1'b0);

        msg.delete();
        run_msg(8'd20, 2, 1'b0);

        msg.delete();
        for (int j = 0; j < 64; j++) msg.push_back(8'(j));
        run_msg(8'd32, 1, 1'b0);

        fill_rand(65);
        run_msg(8'd28, 1, 1'b0);

        fill_rand($urandom_range(1, 200));
        run_msg(8'($urandom_range(1, 32)), 10, 1'b0);

        fill_rand($urandom_range(1, 100));
        run_msg(8'd16, 0, 1'b1);

        fill_rand(128);
        run_msg(8'd32, 3, 1'b0);

        // Reset in the middle of a stream
        msg = {8'h11, 8'h22, 8'h33};
        start_msg(8'd16);
        drive_bytes();
        core_ready_i = 1'b1;
        @(negedge clk);
        core_ready_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("idx_before_rst", data_idx_o, 20);
        nreset = 1'b1;
        @(negedge clk);
        nreset = 1'b0;
        chk_reset_outputs("midrst");
        @(negedge clk);
        chk("idle_after_rst", busy_o, 0);

        for (int r = 0; r < 3; r++) begin
            fill_rand($urandom_range(0, 192));
            run_msg(8'($urandom_range(1, 32)), $urandom_range(0, 4), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
